// File: rtl/pos_aim_ctrl_if.sv
// Per-player button levels in, packed x/aim positions and moved pulses out.
// Level-sampled on tick cycles; no backpressure (outputs are registered state).
interface pos_aim_ctrl_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int X_WIDTH     = 5,
  parameter int AIM_WIDTH   = 3
);
  logic                             tick;
  logic                             wrap_x;
  logic [NUM_PLAYERS-1:0]           left_x;
  logic [NUM_PLAYERS-1:0]           right_x;
  logic [NUM_PLAYERS-1:0]           left_aim;
  logic [NUM_PLAYERS-1:0]           right_aim;
  logic [NUM_PLAYERS-1:0]           recenter;
  logic [NUM_PLAYERS*X_WIDTH-1:0]   x_pos;
  logic [NUM_PLAYERS*AIM_WIDTH-1:0] aim_pos;
  logic [NUM_PLAYERS-1:0]           x_moved;
  logic [NUM_PLAYERS-1:0]           aim_moved;

  modport master (
    output tick, wrap_x, left_x, right_x, left_aim, right_aim, recenter,
    input  x_pos, aim_pos, x_moved, aim_moved
  );

  modport slave (
    input  tick, wrap_x, left_x, right_x, left_aim, right_aim, recenter,
    output x_pos, aim_pos, x_moved, aim_moved
  );
endinterface

// File: rtl/pos_aim_ctrl.sv
// Multi-player x/aim controller with hold-to-repeat; updates on tick, results one clk later.
// No backpressure: inputs are levels sampled on tick cycles, outputs are registered.
module pos_aim_axis #(
  parameter int W            = 5,
  parameter int VMAX         = 31,
  parameter int VRESET       = 0,
  parameter int REPEAT_DELAY = 4,
  parameter int REPEAT_RATE  = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tick,
  input  logic         wrap,
  input  logic         dec,
  input  logic         inc,
  input  logic         recenter,
  output logic [W-1:0] pos,
  output logic         moved
);
  localparam int MAX_DR = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW     = $clog2(MAX_DR) + 1;
  localparam logic [CW-1:0] DELAY_LOAD = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LOAD  = CW'(REPEAT_RATE - 1);
  localparam logic [W-1:0]  VMAX_V     = W'(VMAX);
  localparam logic [W-1:0]  VRESET_V   = W'(VRESET);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [W-1:0]  pos_q, pos_d, step_val;
  logic          moved_q, moved_d;
  logic          req, step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      pos_q   <= VRESET_V;
      moved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
      moved_q <= moved_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    step     = 1'b0;
    pos_d    = pos_q;
    moved_d  = 1'b0;
    step_val = pos_q;
    req      = inc ^ dec;

    if (tick) begin
      if (recenter || !req) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (state_q == IDLE || inc != dir_q) begin
        // Fresh press or reversal: step now and restart the hold timing.
        step  = 1'b1;
        dir_d = inc;
        if (REPEAT_DELAY == 1) begin
          state_d = REPEAT;
          cnt_d   = RATE_LOAD;
        end else begin
          state_d = DELAY;
          cnt_d   = DELAY_LOAD;
        end
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        step    = 1'b1;
        state_d = REPEAT;
        cnt_d   = RATE_LOAD;
      end
    end

    if (dir_d)
      step_val = (pos_q == VMAX_V) ? (wrap ? '0 : pos_q) : pos_q + W'(1);
    else
      step_val = (pos_q == '0) ? (wrap ? VMAX_V : pos_q) : pos_q - W'(1);

    if (tick && recenter)
      pos_d = VRESET_V;
    else if (step)
      pos_d = step_val;

    moved_d = (pos_d != pos_q);
  end

  assign pos   = pos_q;
  assign moved = moved_q;
endmodule

module pos_aim_ctrl #(
  parameter int NUM_PLAYERS  = 2,
  parameter int X_WIDTH      = 5,
  parameter int X_MAX        = 31,
  parameter int X_RESET      = 0,
  parameter int AIM_WIDTH    = 3,
  parameter int AIM_MAX      = 6,
  parameter int AIM_CENTER   = 3,
  parameter int REPEAT_DELAY = 4,
  parameter int REPEAT_RATE  = 2
) (
  input logic          clk,
  input logic          reset_n,
  pos_aim_ctrl_if.slave bus
);
  logic [NUM_PLAYERS*X_WIDTH-1:0]   x_pos_w;
  logic [NUM_PLAYERS*AIM_WIDTH-1:0] aim_pos_w;
  logic [NUM_PLAYERS-1:0]           x_moved_w;
  logic [NUM_PLAYERS-1:0]           aim_moved_w;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    pos_aim_axis #(
      .W(X_WIDTH), .VMAX(X_MAX), .VRESET(X_RESET),
      .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
    ) u_x (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (bus.tick),
      .wrap     (bus.wrap_x),
      .dec      (bus.left_x[p]),
      .inc      (bus.right_x[p]),
      .recenter (1'b0),
      .pos      (x_pos_w[p*X_WIDTH +: X_WIDTH]),
      .moved    (x_moved_w[p])
    );

    // Aim never wraps; its reset value doubles as the recentre target.
    pos_aim_axis #(
      .W(AIM_WIDTH), .VMAX(AIM_MAX), .VRESET(AIM_CENTER),
      .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
    ) u_aim (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (bus.tick),
      .wrap     (1'b0),
      .dec      (bus.left_aim[p]),
      .inc      (bus.right_aim[p]),
      .recenter (bus.recenter[p]),
      .pos      (aim_pos_w[p*AIM_WIDTH +: AIM_WIDTH]),
      .moved    (aim_moved_w[p])
    );
  end

  assign bus.x_pos     = x_pos_w;
  assign bus.aim_pos   = aim_pos_w;
  assign bus.x_moved   = x_moved_w;
  assign bus.aim_moved = aim_moved_w;
endmodule

// File: tb/tb_pos_aim_ctrl.sv
// Bench for pos_aim_ctrl: fixed vector table, directed multi-cycle sequences, and
// random stimulus against a hold-count reference model.
module tb_pos_aim_ctrl;
  localparam int NP = 2, XW = 5, XMAX = 31, XRST = 0, AW = 3, AMAX = 6, ACTR = 3;
  localparam int RD = 4, RR = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pos_aim_ctrl_if #(.NUM_PLAYERS(NP), .X_WIDTH(XW), .AIM_WIDTH(AW)) bus ();

  pos_aim_ctrl #(
    .NUM_PLAYERS(NP), .X_WIDTH(XW), .X_MAX(XMAX), .X_RESET(XRST),
    .AIM_WIDTH(AW), .AIM_MAX(AMAX), .AIM_CENTER(ACTR),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: each axis tracks how many consecutive ticks the same single
  // direction has been requested; steps happen on hold tick 1, then first, first+RR, ...
  int xv[NP], av[NP], xn[NP], an[NP];
  bit xd[NP], ad[NP];
  bit [NP-1:0] exm, eam;

  function automatic bit rep_step(int n);
    int first;
    first = 1 + ((RD == 1) ? RR : RD);
    return (n == 1) || (n >= first && ((n - first) % RR) == 0);
  endfunction

  function automatic int nudge(int v, bit up, int vmax, bit wr);
    if (up) return (v == vmax) ? (wr ? 0 : v) : v + 1;
    return (v == 0) ? (wr ? vmax : 0) : v - 1;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      xv[p] = XRST; av[p] = ACTR; xn[p] = 0; an[p] = 0; xd[p] = 0; ad[p] = 0;
    end
    exm = '0; eam = '0;
  endtask

  task automatic model_tick();
    int nv;
    exm = '0; eam = '0;
    for (int p = 0; p < NP; p++) begin
      nv = xv[p];
      if (bus.left_x[p] == bus.right_x[p]) xn[p] = 0;
      else begin
        if (xn[p] == 0 || xd[p] != bus.right_x[p]) begin
          xn[p] = 1; xd[p] = bus.right_x[p];
        end else xn[p]++;
        if (rep_step(xn[p])) nv = nudge(xv[p], xd[p], XMAX, bus.wrap_x);
      end
      exm[p] = (nv != xv[p]); xv[p] = nv;

      nv = av[p];
      if (bus.recenter[p]) begin
        an[p] = 0; nv = ACTR;
      end else if (bus.left_aim[p] == bus.right_aim[p]) an[p] = 0;
      else begin
        if (an[p] == 0 || ad[p] != bus.right_aim[p]) begin
          an[p] = 1; ad[p] = bus.right_aim[p];
        end else an[p]++;
        if (rep_step(an[p])) nv = nudge(av[p], ad[p], AMAX, 1'b0);
      end
      eam[p] = (nv != av[p]); av[p] = nv;
    end
  endtask

  task automatic check_outputs(string nm);
    logic [NP*XW-1:0] ex;
    logic [NP*AW-1:0] ea;
    for (int p = 0; p < NP; p++) begin
      ex[p*XW +: XW] = XW'(xv[p]);
      ea[p*AW +: AW] = AW'(av[p]);
    end
    checks++;
    if (bus.x_pos !== ex || bus.aim_pos !== ea || bus.x_moved !== exm || bus.aim_moved !== eam) begin
      errors++;
      $display("FAIL %s: got x_pos=%h aim_pos=%h x_moved=%b aim_moved=%b, expected %h %h %b %b",
               nm, bus.x_pos, bus.aim_pos, bus.x_moved, bus.aim_moved, ex, ea, exm, eam);
    end
  endtask

  task automatic set_in(bit w, bit [NP-1:0] lx, bit [NP-1:0] rx, bit [NP-1:0] la,
                        bit [NP-1:0] ra, bit [NP-1:0] rc);
    bus.wrap_x = w; bus.left_x = lx; bus.right_x = rx;
    bus.left_aim = la; bus.right_aim = ra; bus.recenter = rc;
  endtask

  task automatic cyc(bit t, string nm);
    bus.tick = t;
    if (t) model_tick();
    else begin exm = '0; eam = '0; end
    @(posedge clk); #1;
    check_outputs(nm);
  endtask

  task automatic do_reset(string nm);
    reset_n = 1'b0;
    #2;
    model_reset();
    check_outputs(nm);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit t; bit w;
    bit [1:0] lx, rx, la, ra, rc;
    int x0, x1, a0, a1;
    bit [1:0] xm, am;
  } vec_t;
  vec_t vt[12];

  int pulses;

  initial begin
    bus.tick = 1'b0;
    set_in(1'b0, '0, '0, '0, '0, '0);

    //          t  w  lx     rx     la     ra     rc     x0 x1 a0 a1 xm     am
    vt[0]  = '{1, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 3, 3, 2'b01, 2'b00};
    vt[1]  = '{0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 3, 3, 2'b00, 2'b00};
    vt[2]  = '{1, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 3, 3, 2'b00, 2'b00};
    vt[3]  = '{1, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 3, 3, 2'b00, 2'b00};
    vt[4]  = '{1, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 3, 3, 2'b00, 2'b00};
    vt[5]  = '{1, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2, 0, 3, 3, 2'b01, 2'b00};
    vt[6]  = '{1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2, 0, 3, 3, 2'b00, 2'b00};
    vt[7]  = '{1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 3, 3, 2'b01, 2'b00};
    vt[8]  = '{1, 0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1, 0, 3, 2, 2'b00, 2'b10};
    vt[9]  = '{1, 0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 1, 0, 3, 3, 2'b00, 2'b10};
    vt[10] = '{1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1, 0, 3, 3, 2'b00, 2'b00};
    vt[11] = '{1, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1, 31, 3, 3, 2'b10, 2'b00};

    // Reset with buttons held, then release without ticks.
    @(negedge clk);
    set_in(1'b0, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00);
    do_reset("reset_held");
    for (int i = 0; i < 3; i++) cyc(1'b0, "post_reset_no_tick");

    for (int i = 0; i < 12; i++) begin
      set_in(vt[i].w, vt[i].lx, vt[i].rx, vt[i].la, vt[i].ra, vt[i].rc);
      bus.tick = vt[i].t;
      @(posedge clk); #1;
      checks++;
      if (bus.x_pos !== {XW'(vt[i].x1), XW'(vt[i].x0)} ||
          bus.aim_pos !== {AW'(vt[i].a1), AW'(vt[i].a0)} ||
          bus.x_moved !== vt[i].xm || bus.aim_moved !== vt[i].am) begin
        errors++;
        $display("FAIL vector %0d: got x_pos=%h aim_pos=%h xm=%b am=%b, expected x=%0d/%0d aim=%0d/%0d xm=%b am=%b",
                 i, bus.x_pos, bus.aim_pos, bus.x_moved, bus.aim_moved,
                 vt[i].x1, vt[i].x0, vt[i].a1, vt[i].a0, vt[i].xm, vt[i].am);
      end
    end

    // Auto-repeat with a tick every 4 clocks.
    set_in(1'b0, '0, '0, '0, '0, '0);
    bus.tick = 1'b0;
    do_reset("reset_repeat");
    set_in(1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 3; j++) begin cyc(1'b0, "repeat_gap"); pulses += int'(bus.x_moved[0]); end
      cyc(1'b1, "repeat_tick"); pulses += int'(bus.x_moved[0]);
    end
    chk("repeat_final_x0", int'(bus.x_pos[XW-1:0]), 4);
    chk("repeat_pulses", pulses, 4);

    // Reversal mid-REPEAT: immediate step, then a 3-tick pause.
    do_reset("reset_reverse");
    for (int k = 0; k < 7; k++) cyc(1'b1, "rev_hold_right");
    chk("rev_before", int'(bus.x_pos[XW-1:0]), 3);
    set_in(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(1'b1, "rev_first_left");
    chk("rev_immediate", int'(bus.x_pos[XW-1:0]), 2);
    for (int k = 0; k < 3; k++) cyc(1'b1, "rev_delay");
    chk("rev_delay_hold", int'(bus.x_pos[XW-1:0]), 2);
    cyc(1'b1, "rev_repeat");
    chk("rev_next_step", int'(bus.x_pos[XW-1:0]), 1);

    // X bounds: wrap 0 -> 31, saturate at 31, wrap 31 -> 0.
    set_in(1'b0, '0, '0, '0, '0, '0);
    do_reset("reset_bounds");
    set_in(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(1'b1, "wrap_down");
    chk("wrap_down_x0", int'(bus.x_pos[XW-1:0]), 31);
    set_in(1'b0, '0, '0, '0, '0, '0);
    cyc(1'b1, "release");
    set_in(1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 6; k++) cyc(1'b1, "sat_hold");
    chk("sat_x0", int'(bus.x_pos[XW-1:0]), 31);
    chk("sat_no_pulse", int'(bus.x_moved[0]), 0);
    set_in(1'b0, '0, '0, '0, '0, '0);
    cyc(1'b1, "release");
    set_in(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    cyc(1'b1, "wrap_up");
    chk("wrap_up_x0", int'(bus.x_pos[XW-1:0]), 0);
    chk("wrap_up_pulse", int'(bus.x_moved[0]), 1);

    // Aim saturation and recentre overriding a held button.
    set_in(1'b0, '0, '0, '0, '0, '0);
    do_reset("reset_aim");
    set_in(1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
    for (int k = 0; k < 9; k++) cyc(1'b1, "aim_hold");
    chk("aim_sat", int'(bus.aim_pos[2*AW-1:AW]), 6);
    chk("aim_sat_no_pulse", int'(bus.aim_moved[1]), 0);
    set_in(1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10);
    cyc(1'b1, "aim_recenter");
    chk("aim_recentered", int'(bus.aim_pos[2*AW-1:AW]), 3);
    chk("aim_recenter_pulse", int'(bus.aim_moved[1]), 1);
    set_in(1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
    cyc(1'b1, "aim_after_recenter");
    chk("aim_restart", int'(bus.aim_pos[2*AW-1:AW]), 2);

    // Reset mid-hold; the still-held button is a new press afterwards.
    set_in(1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    do_reset("reset_pre_hold");
    for (int k = 0; k < 6; k++) cyc(1'b1, "hold_before_reset");
    do_reset("reset_mid_hold");
    cyc(1'b1, "hold_after_reset");
    chk("new_press_after_reset", int'(bus.x_pos[XW-1:0]), 1);

    // Independent players, then a long tick-low stretch.
    set_in(1'b1, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00);
    do_reset("reset_indep");
    for (int k = 0; k < 9; k++) cyc(1'b1, "indep");
    for (int k = 0; k < 20; k++) cyc(1'b0, "tick_low");
    chk("indep_x0", int'(bus.x_pos[XW-1:0]), 28);
    chk("indep_x1", int'(bus.x_pos[2*XW-1:XW]), 4);

    // Random stimulus against the model.
    set_in(1'b0, '0, '0, '0, '0, '0);
    do_reset("reset_random");
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) bus.left_x    = NP'($urandom);
      if ($urandom_range(0, 7) == 0) bus.right_x   = NP'($urandom);
      if ($urandom_range(0, 7) == 0) bus.left_aim  = NP'($urandom);
      if ($urandom_range(0, 7) == 0) bus.right_aim = NP'($urandom);
      if ($urandom_range(0, 31) == 0) bus.wrap_x = ~bus.wrap_x;
      for (int p = 0; p < NP; p++) bus.recenter[p] = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 399) == 0) do_reset("random_reset");
      cyc($urandom_range(0, 3) != 0, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
